// File: rtl/serial_add_arbiter_if.sv
// Request/response handshake bundle between two requesters and serial_add_arbiter.
// master = requester side, slave = arbiter side.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_sum;
    logic             rsp0_cout;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_sum;
    logic             rsp1_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_sum, rsp0_cout,
        input  rsp1_valid, rsp1_sum, rsp1_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_sum, rsp0_cout,
        output rsp1_valid, rsp1_sum, rsp1_cout
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter that time-shares one external 1-bit full adder, LSB-first.
// Define SERIAL_ADD_SUB_EN to honour reqN_sub (a-b via inverted B and carry-in 1).
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_arbiter_if.slave  bus,
    output logic                 fa_a,
    output logic                 fa_b,
    output logic                 fa_cin,
    input  logic                 fa_sum,
    input  logic                 fa_cout,
    output logic                 busy
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, r_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic             owner_reg;
    logic             last_reg;

    logic             grant_any, grant_one, accept, rsp_fire;
    logic [WIDTH-1:0] a_sel, b_sel, b_in;
    logic             cin_in;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant_one = bus.req1_valid & (~bus.req0_valid | ~last_reg);
        accept    = (state_reg == IDLE) & grant_any;
        rsp_fire  = (state_reg == DONE) & (owner_reg ? bus.rsp1_ready : bus.rsp0_ready);
        a_sel     = grant_one ? bus.req1_a : bus.req0_a;
        b_sel     = grant_one ? bus.req1_b : bus.req0_b;
    end

`ifdef SERIAL_ADD_SUB_EN
    logic sub_sel;
    always_comb begin
        sub_sel = grant_one ? bus.req1_sub : bus.req0_sub;
        b_in    = sub_sel ? ~b_sel : b_sel;
        cin_in  = sub_sel;
    end
`else
    logic unused_sub;
    assign unused_sub = bus.req0_sub ^ bus.req1_sub;
    always_comb begin
        b_in   = b_sel;
        cin_in = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (accept) begin
                    a_reg     <= a_sel;
                    b_reg     <= b_in;
                    owner_reg <= grant_one;
                    idx_reg   <= '0;
                    carry_reg <= cin_in;
                end
                RUN: begin
                    r_reg[idx_reg] <= fa_sum;
                    carry_reg      <= fa_cout;
                    // Hold at the top bit so the index never wraps.
                    if (idx_reg != IDX_LAST) idx_reg <= idx_reg + 1'b1;
                end
                DONE: if (rsp_fire) last_reg <= owner_reg;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (idx_reg == IDX_LAST) state_next = DONE;
            DONE:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = rst & (state_reg == IDLE) & bus.req0_valid & ~grant_one;
        bus.req1_ready = rst & (state_reg == IDLE) & grant_one;
        bus.rsp0_valid = 1'b0;
        bus.rsp0_sum   = '0;
        bus.rsp0_cout  = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp1_sum   = '0;
        bus.rsp1_cout  = 1'b0;
        fa_a           = 1'b0;
        fa_b           = 1'b0;
        fa_cin         = 1'b0;
        busy           = (state_reg != IDLE);
        case (state_reg)
            RUN: begin
                fa_a   = a_reg[idx_reg];
                fa_b   = b_reg[idx_reg];
                fa_cin = carry_reg;
            end
            DONE: begin
                if (owner_reg) begin
                    bus.rsp1_valid = 1'b1;
                    bus.rsp1_sum   = r_reg;
                    bus.rsp1_cout  = carry_reg;
                end else begin
                    bus.rsp0_valid = 1'b1;
                    bus.rsp0_sum   = r_reg;
                    bus.rsp0_cout  = carry_reg;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: directed plan steps plus random traffic,
// checked against an arithmetic reference model and a round-robin fairness model.
module tb_serial_add_arbiter;
    localparam int W = 8;

`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fa_a, fa_b, fa_cin, fa_sum, fa_cout, busy;

    serial_add_arbiter_if #(.WIDTH(W)) bus ();

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_cin (fa_cin),
        .fa_sum (fa_sum),
        .fa_cout(fa_cout),
        .busy   (busy)
    );

    // The shared full-adder cell lives outside the block.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_err   = 0;
    int tb_last = 1;
    bit         pend [2];
    logic [W-1:0] pa [2];
    logic [W-1:0] pb [2];
    bit         ps [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int r);
        return (r == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction
    function automatic logic rv(input int r);
        return (r == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction
    function automatic logic [W-1:0] rs(input int r);
        return (r == 0) ? bus.rsp0_sum : bus.rsp1_sum;
    endfunction
    function automatic logic rc(input int r);
        return (r == 0) ? bus.rsp0_cout : bus.rsp1_cout;
    endfunction

    // Reference result: {cout, sum} from plain integer arithmetic.
    function automatic logic [W:0] ref_result(input int ai, input int bi, input bit s);
        if (SUB_ON && s) return {(ai >= bi) ? 1'b1 : 1'b0, W'(ai - bi)};
        return (W + 1)'(ai + bi);
    endfunction

    task automatic drive(input int r);
        if (r == 0) begin
            bus.req0_valid = pend[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0]; bus.req0_sub = ps[0];
        end else begin
            bus.req1_valid = pend[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1]; bus.req1_sub = ps[1];
        end
    endtask

    task automatic offer(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        pend[r] = 1'b1; pa[r] = a; pb[r] = b; ps[r] = s;
        drive(r);
    endtask

    task automatic set_rr(input int r, input logic v);
        if (r == 0) bus.rsp0_ready = v; else bus.rsp1_ready = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fa"},   32'({fa_a, fa_b, fa_cin}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"},  32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        chk({tag, "_rsp"},  32'({bus.rsp0_valid, bus.rsp0_sum, bus.rsp0_cout,
                                 bus.rsp1_valid, bus.rsp1_sum, bus.rsp1_cout}), 32'd0);
    endtask

    // Serve the next operation the round-robin model predicts, with the
    // winner's rsp_ready held low for 'hold' cycles in DONE.
    task automatic serve(input int hold);
        int w, waited, ai, bi, ebi, c0, mask, cin_k;
        logic [W:0] exp_res;
        bit s;
        if (pend[0] && pend[1]) w = (tb_last == 1) ? 0 : 1;
        else if (pend[0])       w = 0;
        else                    w = 1;
        #1;
        chk("idle_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        waited = 0;
        while (!rdy(w) && waited < W + 4) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("grant_wait", 32'(waited), 32'd0);
        chk("ready_other", 32'(rdy(1 - w)), 32'd0);
        ai = int'(pa[w]); bi = int'(pb[w]); s = ps[w];
        ebi = (SUB_ON && s) ? (~bi & 32'hFF) : bi;
        c0  = (SUB_ON && s) ? 1 : 0;
        exp_res = ref_result(ai, bi, s);
        set_rr(w, (hold == 0) ? 1'b1 : 1'b0);
        @(posedge clk); #1;
        pend[w] = 1'b0;
        drive(w);
        for (int k = 0; k <= W; k++) begin
            chk("rsp_other_idle", 32'(rv(1 - w)), 32'd0);
            chk("busy_op", 32'(busy), 32'd1);
            chk("ready_op", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            if (k < W) begin
                mask  = (1 << k) - 1;
                cin_k = ((ai & mask) + (ebi & mask) + c0) >> k;
                chk("rsp_early", 32'(rv(w)), 32'd0);
                chk("fa_a_bit",  32'(fa_a), 32'((ai >> k) & 1));
                chk("fa_b_bit",  32'(fa_b), 32'((ebi >> k) & 1));
                chk("fa_cin",    32'(fa_cin), 32'(cin_k & 1));
                @(posedge clk); #1;
            end else begin
                chk("rsp_valid", 32'(rv(w)), 32'd1);
                chk("rsp_sum",   32'(rs(w)), 32'(exp_res[W-1:0]));
                chk("rsp_cout",  32'(rc(w)), 32'(exp_res[W]));
                chk("done_fa",   32'({fa_a, fa_b, fa_cin}), 32'd0);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rv(w)), 32'd1);
            chk("hold_sum",   32'(rs(w)), 32'(exp_res[W-1:0]));
            chk("hold_cout",  32'(rc(w)), 32'(exp_res[W]));
            chk("hold_busy",  32'(busy), 32'd1);
            chk("hold_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        set_rr(w, 1'b1);
        @(posedge clk); #1;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_rsp",  32'(rv(w)), 32'd0);
        tb_last = w;
        $display("op req%0d a=%02h b=%02h sub=%0d hold=%0d -> sum=%02h cout=%0d", w, ai, bi, s, hold,
                 exp_res[W-1:0], exp_res[W]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pend[0] = 0; pend[1] = 0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; ps[0] = 0; ps[1] = 0;
        drive(0); drive(1);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset with both requesters asserting valid: every output must be 0.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #12;
        chk_all_zero("reset");
        drive(0); drive(1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all_zero("released");

        // Directed plan steps.
        offer(0, 8'h35, 8'h4A, 1'b0); serve(0);
        offer(1, 8'hFF, 8'h01, 1'b0); serve(0);

        // Both valid: order req0, req1, req0, req1.
        offer(0, 8'h01, 8'h01, 1'b0); offer(1, 8'h02, 8'h02, 1'b0);
        serve(0);
        offer(0, 8'h01, 8'h01, 1'b0);
        serve(0);
        offer(1, 8'h02, 8'h02, 1'b0);
        serve(0);
        serve(0);

        // Back-pressure in DONE with the other requester waiting.
        offer(0, 8'hA5, 8'h3C, 1'b0); offer(1, 8'h11, 8'h22, 1'b0);
        serve(5);
        serve(0);

        // Reset while the bit walk is at idx 3.
        offer(0, 8'h35, 8'h4A, 1'b0);
        #1;
        chk("mid_ready", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        pend[0] = 1'b0; drive(0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        tb_last = 1;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_reset", 32'({bus.rsp0_valid, bus.rsp1_valid, busy}), 32'd0);
        end
        offer(0, 8'h10, 8'h20, 1'b0); serve(0);

        // Subtract requests (plain adds when the option is compiled out).
        offer(0, 8'h10, 8'h01, 1'b1); serve(0);
        offer(1, 8'h01, 8'h02, 1'b1); serve(0);

        // Random traffic.
        for (int i = 0; i < 24; i++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 1) == 1)
                    offer(r, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            if (!pend[0] && !pend[1])
                offer(int'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            serve(int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 2; i++)
            if (pend[0] || pend[1]) serve(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
